// File: rtl/spb_pkg.sv
// rtl/spb_pkg.sv - SPB arbiter shared types and bus widths
package spb_pkg;
  localparam int SPB_ADDR_W = 32;
  localparam int SPB_DATA_W = 32;
  localparam int SPB_WSTB_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } arb_state_t;
endpackage

// File: rtl/spb_arb_rr.sv
// rtl/spb_arb_rr.sv - two-input round-robin pick (combinational)
module spb_arb_rr
  import spb_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       prio_i,
  output logic       gnt_o
);
  // gnt_o is the index of the winning requester; prio_i breaks ties
  always_comb begin
    unique case (valid_i)
      2'b11:   gnt_o = prio_i;
      2'b10:   gnt_o = 1'b1;
      default: gnt_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/spb_arb.sv
// rtl/spb_arb.sv - two-requester round-robin SPB arbiter; optional busy timeout via SPB_ARB_TIMEOUT_EN
module spb_arb
  import spb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  S0_SPB_VALID,
  input  logic [SPB_WSTB_W-1:0] S0_SPB_WSTB,
  input  logic [SPB_ADDR_W-1:0] S0_SPB_ADDR,
  input  logic [SPB_DATA_W-1:0] S0_SPB_WDATA,
  output logic                  S0_SPB_READY,
  output logic [SPB_DATA_W-1:0] S0_SPB_RDATA,
  output logic                  S0_SPB_EXCPT,
  input  logic                  S1_SPB_VALID,
  input  logic [SPB_WSTB_W-1:0] S1_SPB_WSTB,
  input  logic [SPB_ADDR_W-1:0] S1_SPB_ADDR,
  input  logic [SPB_DATA_W-1:0] S1_SPB_WDATA,
  output logic                  S1_SPB_READY,
  output logic [SPB_DATA_W-1:0] S1_SPB_RDATA,
  output logic                  S1_SPB_EXCPT,
  output logic                  M_SPB_VALID,
  output logic [SPB_WSTB_W-1:0] M_SPB_WSTB,
  output logic [SPB_ADDR_W-1:0] M_SPB_ADDR,
  output logic [SPB_DATA_W-1:0] M_SPB_WDATA,
  input  logic                  M_SPB_READY,
  input  logic [SPB_DATA_W-1:0] M_SPB_RDATA,
  input  logic                  M_SPB_EXCPT
);
  arb_state_t state_q, state_d;
  logic       prio_q, prio_d;
  logic       rr_gnt;
  logic       busy, sel, req_valid, done, tmo;
  logic                  resp_ready, resp_excpt;
  logic [SPB_DATA_W-1:0] resp_rdata;

  spb_arb_rr u_rr (
    .valid_i ({S1_SPB_VALID, S0_SPB_VALID}),
    .prio_i  (prio_q),
    .gnt_o   (rr_gnt)
  );

  assign busy      = (state_q != IDLE);
  assign sel       = (state_q == BUSY1);
  assign req_valid = busy && (sel ? S1_SPB_VALID : S0_SPB_VALID);
  assign done      = req_valid && M_SPB_READY;

`ifdef SPB_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_q, tmo_cnt_d;

  // a real completion in the last cycle beats the forced abort
  assign tmo = req_valid && !M_SPB_READY && (tmo_cnt_q == TMO_LAST);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (!busy)             tmo_cnt_d = '0;
    else if (!M_SPB_READY) tmo_cnt_d = tmo_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
  assign tmo            = 1'b0;
`endif

  assign M_SPB_VALID = req_valid && !tmo;
  assign M_SPB_WSTB  = busy ? (sel ? S1_SPB_WSTB  : S0_SPB_WSTB)  : '0;
  assign M_SPB_ADDR  = busy ? (sel ? S1_SPB_ADDR  : S0_SPB_ADDR)  : '0;
  assign M_SPB_WDATA = busy ? (sel ? S1_SPB_WDATA : S0_SPB_WDATA) : '0;

  assign resp_ready = done || tmo;
  assign resp_rdata = done ? M_SPB_RDATA : '0;
  assign resp_excpt = done ? M_SPB_EXCPT : tmo;

  assign S0_SPB_READY = resp_ready && !sel;
  assign S1_SPB_READY = resp_ready && sel;
  assign S0_SPB_RDATA = S0_SPB_READY ? resp_rdata : '0;
  assign S1_SPB_RDATA = S1_SPB_READY ? resp_rdata : '0;
  assign S0_SPB_EXCPT = S0_SPB_READY && resp_excpt;
  assign S1_SPB_EXCPT = S1_SPB_READY && resp_excpt;

  // a requester dropping VALID early releases the grant without moving prio
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    unique case (state_q)
      IDLE: begin
        if (S0_SPB_VALID || S1_SPB_VALID) state_d = rr_gnt ? BUSY1 : BUSY0;
      end
      BUSY0, BUSY1: begin
        if (resp_ready) begin
          state_d = IDLE;
          prio_d  = ~sel;
        end else if (!req_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end
endmodule
